// File: rtl/mnist_lut_stream_ctrl.sv
// Credit-based flow controller for the fixed-latency MNIST LUT network, with an FWFT result FIFO.
// Define MNIST_LUT_STREAM_CTRL_PERF_EN to build the source stall-cycle counter.
module mnist_lut_stream_ctrl #(
  parameter int USER_WIDTH   = 8,
  parameter int INPUT_WIDTH  = 784,
  parameter int OUTPUT_WIDTH = 10,
  parameter int FIFO_DEPTH   = 64,
  parameter int CNT_WIDTH    = 7
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic                    cke,
  input  logic [USER_WIDTH-1:0]   s_user,
  input  logic                    s_last,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    net_cke,
  output logic [USER_WIDTH:0]     net_user,
  output logic [INPUT_WIDTH-1:0]  net_data,
  output logic                    net_valid,
  input  logic [USER_WIDTH:0]     net_out_user,
  input  logic [OUTPUT_WIDTH-1:0] net_out_data,
  input  logic                    net_out_valid,
  output logic [USER_WIDTH-1:0]   m_user,
  output logic                    m_last,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [31:0]             stall_cycles
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 1 + USER_WIDTH + OUTPUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [AW-1:0]        LAST_IDX = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] inflight, fifo_count;
  logic [CNT_WIDTH:0]   occupancy;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic                 accepting_state;
  logic                 accept, push, pop, fifo_full, write_en, ret_valid;

  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  assign fifo_full = (fifo_count == DEPTH_C);
  assign m_valid   = (fifo_count != '0);
  assign {m_last, m_user, m_data} = mem[rd_ptr];
  assign net_cke   = cke;

  assign accept    = s_valid & s_ready;
  assign pop       = m_valid & m_ready & cke;
  assign push      = net_out_valid & cke;
  assign write_en  = push & (~fifo_full | pop);
  // A stray result with nothing in flight must not wrap the in-flight count.
  assign ret_valid = push & (inflight != '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else if (cke) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = s_last ? DRAIN : RUN;
      RUN: begin
        if (pop && m_last)         state_next = DONE;
        else if (accept && s_last) state_next = DRAIN;
      end
      DRAIN:   if (pop && m_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accepting_state = (state == IDLE) || (state == RUN);
    s_ready = ~reset & cke & accepting_state & (occupancy < {1'b0, DEPTH_C});
    busy    = (state == RUN) || (state == DRAIN);
    done    = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      net_valid  <= 1'b0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
    end else if (cke) begin
      net_valid <= accept;
      case ({accept, ret_valid})
        2'b10:   inflight <= inflight + CNT_WIDTH'(1);
        2'b01:   inflight <= inflight - CNT_WIDTH'(1);
        default: inflight <= inflight;
      endcase
      case ({write_en, pop})
        2'b10:   fifo_count <= fifo_count + CNT_WIDTH'(1);
        2'b01:   fifo_count <= fifo_count - CNT_WIDTH'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (write_en) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
      if (pop)      rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + AW'(1);
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cke && accept) begin
      net_data <= s_data;
      net_user <= {s_last, s_user};
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[wr_ptr] <= {net_out_user[USER_WIDTH], net_out_user[USER_WIDTH-1:0], net_out_data};
  end

`ifdef MNIST_LUT_STREAM_CTRL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else if (cke && s_valid && !s_ready && accepting_state && (stall_q != '1))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mnist_lut_stream_ctrl.sv
// Bench for mnist_lut_stream_ctrl: latency-10 network model, scoreboard of expected results,
// directed vector table plus streaming/backpressure/overflow scenarios.
module tb_mnist_lut_stream_ctrl;

  localparam int UW    = 8;
  localparam int IW    = 784;
  localparam int OW    = 10;
  localparam int DEPTH = 64;
  localparam int LAT   = 10;

  typedef struct { logic [UW:0] user; logic [OW-1:0] data; } item_t;
  typedef struct { bit cke; bit s_valid; bit exp_s_ready; bit exp_busy; bit exp_net_valid; } vec_t;

  logic clk = 1'b0, reset = 1'b1, cke = 1'b1;
  logic [UW-1:0] s_user = '0;
  logic s_last = 1'b0, s_valid = 1'b0, s_ready;
  logic [IW-1:0] s_data = '0;
  logic net_cke, net_valid, net_out_valid;
  logic [UW:0] net_user, net_out_user;
  logic [IW-1:0] net_data;
  logic [OW-1:0] net_out_data, m_data;
  logic [UW-1:0] m_user;
  logic m_last, m_valid, m_ready = 1'b0;
  logic busy, done, overflow;
  logic [31:0] stall_cycles;

  mnist_lut_stream_ctrl #(.USER_WIDTH(UW), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW),
                          .FIFO_DEPTH(DEPTH), .CNT_WIDTH(7)) dut (
    .reset(reset), .clk(clk), .cke(cke),
    .s_user(s_user), .s_last(s_last), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .net_cke(net_cke), .net_user(net_user), .net_data(net_data), .net_valid(net_valid),
    .net_out_user(net_out_user), .net_out_data(net_out_data), .net_out_valid(net_out_valid),
    .m_user(m_user), .m_last(m_last), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .overflow(overflow), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int n_acc = 0, n_pop = 0, n_done = 0, drop_cnt = 0, done_cyc = 0, last_acc_cyc = 0;
  int acc_cnt = 0, pop_cnt = 0, stall_model = 0, user_ctr = 0;
  int src_left = 0, src_pct = 100, sink_mode = 1;
  bit manual = 0, cke_rand = 0, acc_now = 0, open_s = 0, closed = 0, done_now = 0, done_prev = 0;
  logic inject = 1'b0, inject_counts = 1'b0;
  item_t exp_q[$];
  item_t e;

  always @(posedge clk) cyc++;

  function automatic logic [OW-1:0] netFunc(input logic [IW-1:0] d);
    return d[9:0] ^ d[783:774] ^ d[400:391];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Fixed-latency network: LAT register stages, frozen by net_cke, with an injection port.
  logic          pipe_v [LAT];
  logic [UW:0]   pipe_u [LAT];
  logic [OW-1:0] pipe_d [LAT];
  always @(posedge clk) begin
    if (net_cke) begin
      pipe_v[0] <= net_valid;
      pipe_u[0] <= net_user;
      pipe_d[0] <= netFunc(net_data);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_u[i] <= pipe_u[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign net_out_valid = pipe_v[LAT-1] | inject;
  assign net_out_user  = inject ? 9'h0A5 : pipe_u[LAT-1];
  assign net_out_data  = inject ? 10'h2A5 : pipe_d[LAT-1];

  // Source/sink/cke driver, active unless the vector table owns the pins.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!manual) begin
        if (reset) s_valid = 1'b0;
        else begin
          if (acc_now) begin s_valid = 1'b0; src_left--; end
          if (!s_valid && src_left > 0 && int'($urandom_range(99)) < src_pct) begin
            s_valid = 1'b1;
            s_last  = (src_left == 1);
            s_user  = UW'(user_ctr);
            user_ctr++;
            for (int w = 0; w < IW; w += 16) s_data[w +: 16] = 16'($urandom);
          end
        end
        case (sink_mode)
          0: m_ready = 1'b0;
          1: m_ready = 1'b1;
          2: m_ready = ~m_ready;
          3: m_ready = 1'($urandom_range(1));
          default: m_ready = m_ready;
        endcase
        cke = cke_rand ? ($urandom_range(9) != 0) : 1'b1;
      end
    end
  end

  // Reference model: credits are accepted-minus-delivered frames; results delivered in source order.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        acc_cnt = 0; pop_cnt = 0; stall_model = 0;
        open_s = 0; closed = 0; done_now = 0; done_prev = 0; acc_now = 0;
      end else begin
        checkOutput("s_ready", s_ready, cke && !closed && !done_now && (acc_cnt - pop_cnt) < DEPTH);
        checkOutput("done", done, done_now);
        checkOutput("busy", busy, open_s && !done_now);
        if (s_valid && !s_ready) drop_cnt++;
        if (cke && s_valid && !s_ready && !closed && !done_now) stall_model++;
        if (done && !done_prev) begin n_done++; done_cyc = cyc; end
        done_prev = done;
        acc_now = s_valid && s_ready;
        if (acc_now) begin
          exp_q.push_back('{user: {s_last, s_user}, data: netFunc(s_data)});
          acc_cnt++; n_acc++; open_s = 1; last_acc_cyc = cyc;
          if (s_last) closed = 1;
        end
        if (inject && inject_counts && cke) begin
          exp_q.push_back('{user: 9'h0A5, data: 10'h2A5});
          acc_cnt++;
        end
        e = '{user: '0, data: '0};
        begin
          bit next_done;
          next_done = done_now && !cke;
          if (m_valid && m_ready && cke) begin
            pop_cnt++; n_pop++;
            checkOutput("pop_has_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              checkOutput("m_user", m_user, e.user[UW-1:0]);
              checkOutput("m_last", m_last, e.user[UW]);
              checkOutput("m_data", m_data, e.data);
              if (e.user[UW]) begin next_done = 1; open_s = 0; closed = 0; end
            end
          end
          done_now = next_done;
        end
      end
    end
  end

  task automatic checkStall();
`ifdef MNIST_LUT_STREAM_CTRL_PERF_EN
    checkOutput("stall_cycles", stall_cycles, stall_model);
`else
    checkOutput("stall_cycles", stall_cycles, 0);
`endif
  endtask

  task automatic resetDut();
    cke_rand = 0; src_left = 0; sink_mode = 1;
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (LAT + 5) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_net_valid", net_valid, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_stall", stall_cycles, 0);
    n_acc = 0; n_pop = 0; n_done = 0; drop_cnt = 0;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(posedge clk); #1;
    cke = v.cke; s_valid = v.s_valid; s_last = 1'b0; s_user = UW'(idx + 8'h40); m_ready = 1'b1;
    for (int w = 0; w < IW; w += 16) s_data[w +: 16] = 16'($urandom);
    @(negedge clk); #1;
    checkOutput($sformatf("vec%0d_s_ready", idx), s_ready, v.exp_s_ready);
    checkOutput($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
    checkOutput($sformatf("vec%0d_net_valid", idx), net_valid, v.exp_net_valid);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[8];
    logic [OW-1:0] held_data;
    logic [UW-1:0] held_user;
    int snap;
    vecs[0] = '{0, 1, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0, 0};
    vecs[2] = '{1, 1, 1, 0, 0};
    vecs[3] = '{0, 0, 0, 1, 1};
    vecs[4] = '{1, 0, 1, 1, 1};
    vecs[5] = '{1, 1, 1, 1, 0};
    vecs[6] = '{1, 0, 1, 1, 1};
    vecs[7] = '{1, 0, 1, 1, 0};

    resetDut();
    manual = 1;
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
    @(posedge clk); #1;
    s_valid = 1'b0; cke = 1'b1;
    manual = 0;
    repeat (30) @(posedge clk);
    checkOutput("table_results_drained", exp_q.size(), 0);

    $display("[TB] streaming 10000 frames, sink always ready");
    resetDut();
    src_pct = 100; src_left = 10000;
    for (int i = 0; i < 12000 && n_done == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk); #1;
    checkOutput("stream_accepts", n_acc, 10000);
    checkOutput("stream_results", n_pop, 10000);
    checkOutput("stream_ready_drops", drop_cnt, 0);
    checkOutput("stream_done_pulses", n_done, 1);
    checkOutput("stream_done_delay_ge11", (done_cyc - last_acc_cyc) >= 11, 1);
    checkOutput("stream_queue_empty", exp_q.size(), 0);
    checkOutput("stream_overflow", overflow, 0);

    $display("[TB] sink stalled, continuous source");
    resetDut();
    sink_mode = 0; src_left = 1000;
    for (int i = 0; i < 300 && n_acc < DEPTH; i++) @(negedge clk);
    #1;
    held_data = m_data; held_user = m_user;
    repeat (100) @(negedge clk);
    #1;
    checkOutput("stall_accepts", n_acc, DEPTH);
    checkOutput("stall_s_ready", s_ready, 0);
    checkOutput("stall_m_valid", m_valid, 1);
    checkOutput("stall_m_data_held", m_data, held_data);
    checkOutput("stall_m_user_held", m_user, held_user);
    checkOutput("stall_model_cnt", stall_model >= 100, 1);
    checkStall();

    sink_mode = 4;
    @(posedge clk); #2;
    m_ready = 1'b1; inject = 1'b1; inject_counts = 1'b1;
    @(posedge clk); #2;
    m_ready = 1'b0; inject = 1'b0; inject_counts = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("full_pushpop_overflow", overflow, 0);
    checkOutput("full_pushpop_s_ready", s_ready, 0);

    @(posedge clk); #2;
    inject = 1'b1;
    @(posedge clk); #2;
    inject = 1'b0;
    @(negedge clk); #1;
    checkOutput("overflow_set", overflow, 1);
    sink_mode = 1;
    repeat (100) @(negedge clk);
    #1;
    checkOutput("overflow_sticky", overflow, 1);
    resetDut();
    @(negedge clk); #1;
    checkOutput("overflow_cleared", overflow, 0);

    $display("[TB] alternating sink ready");
    resetDut();
    sink_mode = 2; src_left = 300;
    repeat (60) @(negedge clk);
    #1;
    snap = n_pop;
    repeat (200) @(negedge clk);
    #1;
    checkOutput("alt_half_throughput", n_pop - snap, 100);
    for (int i = 0; i < 2000 && n_done == 0; i++) @(negedge clk);
    #1;
    checkOutput("alt_done", n_done, 1);
    checkOutput("alt_results", n_pop, 300);
    checkOutput("alt_queue_empty", exp_q.size(), 0);
    checkOutput("alt_overflow", overflow, 0);

    $display("[TB] randomized valid/ready/cke");
    resetDut();
    sink_mode = 3; cke_rand = 1; src_pct = 60; src_left = 400;
    for (int i = 0; i < 6000 && n_done == 0; i++) @(negedge clk);
    #1;
    checkOutput("rand_done", n_done, 1);
    checkOutput("rand_accepts", n_acc, 400);
    checkOutput("rand_queue_empty", exp_q.size(), 0);
    checkOutput("rand_overflow", overflow, 0);
    checkStall();
    cke_rand = 0;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mnist_lut_stream_ctrl.md
Name: mnist_lut_stream_ctrl

Overview:
- Flow controller between a ready/valid image source and the fixed-latency, non-stallable MNIST LUT network (cke/valid only, no backpressure).
- Issues frames to the network only when an output slot is guaranteed: credit = FIFO_DEPTH − in-flight − stored.
- Buffers network results in a first-word-fall-through FIFO toward a ready/valid sink.
- Tracks frame sequencing up to the last frame and signals done once it drains.

Parameters:
USER_WIDTH, 8, per-frame side data (label), carried unchanged.
INPUT_WIDTH, 784, image bit width (28*28).
OUTPUT_WIDTH, 10, network output width (CLASS_NUM*CHANNEL_NUM).
FIFO_DEPTH, 64, result FIFO entries; must be ≥ network latency + 2 for full throughput.
CNT_WIDTH, 7, counter width; must hold FIFO_DEPTH.

Ports:
reset  in  1  synchronous, active-high
clk  in  1  single clock
cke  in  1  global clock enable; when 0 all state frozen, s_ready=0, m_valid held
s_user  in  USER_WIDTH  source side data
s_last  in  1  final frame of stream
s_data  in  INPUT_WIDTH  image
s_valid  in  1  source valid
s_ready  out  1  source ready
net_cke  out  1  network clock enable (=cke)
net_user  out  USER_WIDTH+1  {last,user} to network
net_data  out  INPUT_WIDTH  to network
net_valid  out  1  to network
net_out_user  in  USER_WIDTH+1  from network
net_out_data  in  OUTPUT_WIDTH  from network
net_out_valid  in  1  from network
m_user  out  USER_WIDTH  result side data
m_last  out  1  final result
m_data  out  OUTPUT_WIDTH  result
m_valid  out  1  result valid
m_ready  in  1  sink ready
busy  out  1  state RUN or DRAIN
done  out  1  one-cycle pulse after last result accepted
overflow  out  1  sticky: net_out_valid arrived with FIFO full
stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset: s_ready=0, net_valid=0, m_valid=0, busy=0, done=0, overflow=0, inflight=0, fifo_count=0, stall_cycles=0, state=IDLE.
- States:
  - IDLE→RUN on first accept.
  - RUN→DRAIN on accept with s_last=1.
  - DRAIN→DONE on m handshake with m_last=1.
  - DONE→IDLE next cycle; done=1 only in DONE.
  - RUN also exits directly to DONE if the last result is handed off in the same cycle.
- s_ready = cke & (state∈{IDLE,RUN}) & (inflight+fifo_count < FIFO_DEPTH). Combinational from registered counts only; never depends on s_valid.
- Accept = s_valid & s_ready. Next cycle: net_valid=1, net_data=s_data, net_user={s_last,s_user}. Otherwise net_valid=0 and net data/user = X-don't-care.
- inflight: +1 on accept, −1 on net_out_valid, both in same cycle → unchanged.
- fifo_count: +1 on push, −1 on m handshake (m_valid & m_ready), both → unchanged.
- Push = net_out_valid & cke. Pushing while full is dropped and sets overflow (latency-contract violation); overflow clears only on reset.
- FIFO is first-word fall-through: m_valid rises the cycle after a push into an empty FIFO. m_data/m_user/m_last are stable while m_valid & !m_ready.
- Simultaneous push and pop when full: legal, count unchanged, no overflow.
- Throughput: one frame per clock while the sink is always ready and FIFO_DEPTH ≥ latency+2.
- Reset mid-frame: all counters and FIFO cleared; frames in flight in the network are not tracked. The bench holds reset for ≥ network latency so late net_out_valid does not corrupt state.

Optional Feature:
- Macro: MNIST_LUT_STREAM_CTRL_PERF_EN.
- Defined: stall_cycles increments each cke cycle where s_valid=1 & s_ready=0 & state∈{IDLE,RUN}; saturates at 2^32−1; cleared by reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- 10000 frames, m_ready=1, latency 10, FIFO_DEPTH=64 → s_ready never drops after reset; 10000 results in order; m_last only on the 10000th; done pulses once, ≥11 cycles after the last accept.
- m_ready=0 throughout, continuous source → exactly 64 accepts, then s_ready=0; fifo_count+inflight=64; m_data stable.
- Alternate m_ready 1/0 each cycle → 50% throughput; no overflow; user labels match source order.
- Push and pop in the same cycle at FIFO full → fifo_count stays 64; overflow=0.
- Network model that emits an extra net_out_valid while full → overflow=1 and stays 1 until reset.
- With PERF_EN and sink stalled 100 cycles after FIFO fill, s_valid=1 → stall_cycles=100; without the macro it reads 0.
